// File: rtl/cpu_multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// It holds state and ALU-op enums, opcode constants, and the mux/ALU/immediate codes.
package cpu_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_JAL       = 4'd9,
    S_JALR      = 4'd10,
    S_BRANCH    = 4'd11,
    S_UPPER     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_SRC_I = 3'b000;
  localparam logic [2:0] IMM_SRC_S = 3'b001;
  localparam logic [2:0] IMM_SRC_B = 3'b010;
  localparam logic [2:0] IMM_SRC_U = 3'b011;
  localparam logic [2:0] IMM_SRC_J = 3'b100;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_READ_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Immediate format is a pure function of the opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_src_for(input logic [6:0] opc);
    case (opc)
      OPC_STORE:          return IMM_SRC_S;
      OPC_BRANCH:         return IMM_SRC_B;
      OPC_LUI, OPC_AUIPC: return IMM_SRC_U;
      OPC_JAL:            return IMM_SRC_J;
      default:            return IMM_SRC_I;
    endcase
  endfunction

endpackage

// File: rtl/cpu_multicycle_control_alu_decoder.sv
// Combinational ALU control decode from alu_op, funct3, funct7b5 and opcode.
// The opcode separates SUB (register form) from ADDI, which ignores instr[30].
module cpu_multicycle_control_alu_decoder
  import cpu_multicycle_control_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [6:0] opcode_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALU_OP_SUB: alu_ctrl_o = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (funct7b5_i && (opcode_i == OPC_OP)) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Main control FSM of the multicycle RV32I core: one state per cycle over a shared datapath,
// stalling on a ready-handshaked unified memory port.
module cpu_multicycle_control
  import cpu_multicycle_control_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic       illegal_instr
);

  state_t     state_q, state_d;
  alu_op_t    alu_op_s;
  logic       mem_req_s, mem_write_s, adr_src_s, ir_write_s, reg_write_s, illegal_s;
  logic       pc_update_s, branch_s, taken_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s;
  logic [3:0] alu_ctrl_s;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    case (funct3)
      3'b000:  taken_s = alu_zero;
      3'b001:  taken_s = !alu_zero;
      3'b100:  taken_s = alu_lt;
      3'b101:  taken_s = !alu_lt;
      3'b110:  taken_s = alu_ltu;
      3'b111:  taken_s = !alu_ltu;
      default: taken_s = 1'b0;
    endcase
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d      = S_FETCH;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    alu_op_s     = ALU_OP_ADD;
    alu_src_a_s  = SRC_A_PC;
    alu_src_b_s  = SRC_B_RS2;
    result_src_s = RES_ALU_OUT;

    case (state_q)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        ir_write_s   = mem_ready;
        pc_update_s  = mem_ready;
        alu_src_b_s  = SRC_B_FOUR;
        result_src_s = RES_ALU_RESULT;
        state_d      = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_s = SRC_A_OLD_PC;
        alu_src_b_s = SRC_B_IMM;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADR;
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OP_IMM:          state_d = S_EXEC_I;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_LUI, OPC_AUIPC:  state_d = S_UPPER;
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a_s = SRC_A_RS1;
        alu_src_b_s = SRC_B_IMM;
        state_d     = (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        state_d   = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        result_src_s = RES_READ_DATA;
        reg_write_s  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
        state_d     = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        alu_src_a_s = SRC_A_RS1;
        alu_op_s    = ALU_OP_FUNCT;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a_s = SRC_A_RS1;
        alu_src_b_s = SRC_B_IMM;
        alu_op_s    = ALU_OP_FUNCT;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_s = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = SRC_A_OLD_PC;
        alu_src_b_s = SRC_B_FOUR;
        pc_update_s = 1'b1;
        state_d     = S_ALU_WB;
      end
      S_JALR: begin
        alu_src_a_s  = SRC_A_RS1;
        alu_src_b_s  = SRC_B_IMM;
        result_src_s = RES_ALU_RESULT;
        pc_update_s  = 1'b1;
        state_d      = S_ALU_WB;
      end
      S_BRANCH: begin
        alu_src_a_s = SRC_A_RS1;
        alu_op_s    = ALU_OP_SUB;
        branch_s    = 1'b1;
      end
      S_UPPER: begin
        alu_src_a_s = (opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_OLD_PC;
        alu_src_b_s = SRC_B_IMM;
        state_d     = S_ALU_WB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  cpu_multicycle_control_alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op_s),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .opcode_i   (opcode),
    .alu_ctrl_o (alu_ctrl_s)
  );

  // Reset gates every output combinationally so a request in flight drops in the same cycle.
  assign mem_req       = rst_n & mem_req_s;
  assign mem_write     = rst_n & mem_write_s;
  assign adr_src       = rst_n & adr_src_s;
  assign ir_write      = rst_n & ir_write_s;
  assign pc_write      = rst_n & (pc_update_s | (branch_s & taken_s));
  assign reg_write     = rst_n & reg_write_s;
  assign illegal_instr = rst_n & illegal_s;
  assign imm_src       = rst_n ? imm_src_for(opcode) : 3'b000;
  assign alu_src_a     = rst_n ? alu_src_a_s  : 2'b00;
  assign alu_src_b     = rst_n ? alu_src_b_s  : 2'b00;
  assign result_src    = rst_n ? result_src_s : 2'b00;
  assign alu_ctrl      = rst_n ? alu_ctrl_s   : 4'd0;

endmodule
